mux_quad4_1_arb: RTL and testbench
==================================

// Module: mux_quad4_1_arb
// PURPOSE
//  Round-robin arbiter and sequencer for the shared quad 4-1 mux datapath.
//  Four requesters (A..D) compete for the 4-bit output path. The block drives mux select S,
//  returns one-hot grants and registers the selected data with a valid strobe.
//  It sits between the requesters and the existing mux_quad4_1 instance.
// PARAMETERS
//  MAX_HOLD  4  max consecutive grant cycles per owner before forced release (1..15)
//  HOLD_W    4  width of hold counter; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   4  request per source; bit0=A .. bit3=D; held high while owner has data
//  last       in   4  final-beat marker per source; qualified only by gnt of same bit
//  InA..InD   in   4  source data words (4 ports, 4 bits each)
//  gnt        out  4  one-hot grant, registered; 0 when idle
//  S          out  2  mux select, registered; equals index of gnt bit; 0 when idle
//  Out        out  4  registered mux output: data sampled on a transfer cycle
//  out_valid  out  1  high the cycle after each transfer cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, S=0, Out=0, out_valid=0, ptr=0, hold_cnt=0.
//  Transfer cycle = gnt[g] & req[g]. On it, Out<=mux(S), out_valid<=1; otherwise out_valid<=0,
//    Out holds its value.
//  States:
//    IDLE: if |req -> winner w = first set bit of req scanning ptr, ptr+1, .. (mod 4);
//      next cycle gnt=1<<w, S=w, hold_cnt=1, state=GRANT. No req -> stay IDLE.
//    GRANT (owner g): release when any of:
//      (a) last[g] & req[g] (final beat transfers this cycle);
//      (b) req[g]==0 (owner dropped; no transfer);
//      (c) hold_cnt==MAX_HOLD & req[g] (forced; beat transfers).
//      No release -> hold_cnt++, gnt/S unchanged.
//      On release: ptr<=g+1 (mod 4). Winner chosen from the current req with the scan starting
//      at g+1, so g has lowest priority. Winner found -> next cycle GRANT to it,
//      hold_cnt=1 (zero bubble). None -> IDLE, gnt=0, S=0.
//  Req->gnt latency: 1 cycle. Transfer->out_valid/Out: 1 cycle.
//  Sole requester: after forced release (c) it is regranted with no bubble; hold_cnt restarts at 1.
//  Simultaneous last[g] and hold_cnt==MAX_HOLD: a single release with identical effect.
//  last[x] for x!=g is ignored. req changes of non-owners mid-grant do not affect the owner.
//  Reset mid-grant: all outputs return to reset values immediately (async). The in-flight beat
//    is dropped; no out_valid is produced for it.
//  Starvation bound: a continuously requesting source is granted within 3*MAX_HOLD cycles.
// STRUCTURE
//  Package mux_quad4_1_arb_pkg: state enum {IDLE, GRANT}, NUM_REQ=4, SEL_W=2.
//  Sub-module rr_pick4 (combinational): inputs req[3:0], start[1:0]; outputs found, idx[1:0].
//  Datapath: instantiate existing mux_quad4_1 (InA..InD, S -> mux_out). Register mux_out into Out.
//  Top: FSM, ptr, hold_cnt, output registers.
// TESTING (self-checking; compare against a reference model each cycle)
//  1. Reset: rst_n=0 with random inputs -> gnt=0, S=0, Out=0, out_valid=0.
//     Release -> still 0 while req=0.
//  2. Single request: req=0010, InB=9, last[1] on 3rd beat.
//     -> gnt=0010, S=1 one cycle later; 3 Out=9 strobes; then IDLE, gnt=0.
//  3. Round-robin with all requesting: req=1111, last pulsed every beat.
//     -> grant order A,B,C,D,A; S=0,1,2,3,0 on consecutive cycles; no bubble.
//  4. Forced release: MAX_HOLD=4, req=0101 held, last=0.
//     -> A gets 4 transfers, then C gets 4, then A; exactly 4 out_valid per tenure.
//  5. Owner drops: A granted, req[0] falls after 2 beats with req[3]=1.
//     -> no transfer on the drop cycle; D granted next cycle (S=3); ptr=1.
//  6. Async reset mid-grant: assert rst_n=0 between edges during C's tenure.
//     -> gnt, S, out_valid go 0 immediately; after release, arbitration restarts from A.

Source files
------------

// File: rtl/mux_quad4_1_arb_pkg.sv
// Shared types and sizes for the quad 4-1 mux arbiter.
// No logic; no latency.
// No flow control.
package mux_quad4_1_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_quad4_1.sv
// Existing 4-bit quad 4-1 mux: routes one of InA..InD to Y by S.
// Combinational, zero latency.
// No flow control.
module mux_quad4_1 (
    input  logic [3:0] InA,
    input  logic [3:0] InB,
    input  logic [3:0] InC,
    input  logic [3:0] InD,
    input  logic [1:0] S,
    output logic [3:0] Y
);

    always_comb begin
        Y = InA;
        case (S)
            2'd0:    Y = InA;
            2'd1:    Y = InB;
            2'd2:    Y = InC;
            default: Y = InD;
        endcase
    end

endmodule

// File: rtl/mux_quad4_1_arb_rr_pick4.sv
// Rotating first-set-bit picker: scans req from start upward, wrapping mod 4.
// Combinational, zero latency.
// No flow control.
module rr_pick4
    import mux_quad4_1_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + i[SEL_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_quad4_1_arb.sv
// Round-robin arbiter driving the shared quad 4-1 mux select, plus registered output.
// Latency: req->gnt 1 cycle; transfer->Out/out_valid 1 cycle.
// Backpressure: owner holds req while it has data; tenure capped at MAX_HOLD beats.
module mux_quad4_1_arb
    import mux_quad4_1_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [3:0]         InA,
    input  logic [3:0]         InB,
    input  logic [3:0]         InC,
    input  logic [3:0]         InD,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   S,
    output logic [3:0]         Out,
    output logic               out_valid
);

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   s_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;

    logic [SEL_W-1:0]   pick_start;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               xfer;
    logic               owner_req;
    logic               owner_last;
    logic               at_max;
    logic               rel;
    logic [3:0]         mux_out;

    mux_quad4_1 u_mux (
        .InA (InA),
        .InB (InB),
        .InC (InC),
        .InD (InD),
        .S   (S),
        .Y   (mux_out)
    );

    // After a release the scan starts just past the outgoing owner so it ranks last.
    assign pick_start = (state == GRANT) ? S + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req  = req[S];
    assign owner_last = last[S];
    assign xfer       = (state == GRANT) && |(gnt & req);
    assign at_max     = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign rel        = (state == GRANT) &&
                        (!owner_req || owner_last || at_max);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        s_n     = S;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    gnt_n   = NUM_REQ'(1) << pick_idx;
                    s_n     = pick_idx;
                    hold_n  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_n = S + 2'd1;
                    if (pick_found) begin
                        gnt_n  = NUM_REQ'(1) << pick_idx;
                        s_n    = pick_idx;
                        hold_n = HOLD_W'(1);
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        s_n     = '0;
                        hold_n  = '0;
                    end
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                s_n     = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            S        <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            S        <= s_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                Out <= mux_out;
            end
        end
    end

endmodule

// File: tb/tb_mux_quad4_1_arb.sv
// Directed bench for mux_quad4_1_arb with hand-computed per-cycle expectations.
module tb_mux_quad4_1_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] InA, InB, InC, InD;
    logic [3:0] gnt;
    logic [1:0] S;
    logic [3:0] Out;
    logic       out_valid;

    int checks;
    int failures;

    mux_quad4_1_arb #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .InA       (InA),
        .InB       (InB),
        .InC       (InC),
        .InD       (InD),
        .gnt       (gnt),
        .S         (S),
        .Out       (Out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req  = 4'($urandom);
            last = 4'($urandom);
            InA  = 4'($urandom);
            InB  = 4'($urandom);
            InC  = 4'($urandom);
            InD  = 4'($urandom);
            step();
        end
        checks++;
        if ({gnt, S, Out, out_valid} !== 11'd0) begin
            failures++;
            $display("FAIL reset_hold got gnt=%b S=%0d Out=%h ov=%b want all 0", gnt, S, Out, out_valid);
        end
        req   = '0;
        last  = '0;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, S, Out, out_valid} !== 11'd0) begin
            failures++;
            $display("FAIL reset_idle got gnt=%b S=%0d Out=%h ov=%b want all 0", gnt, S, Out, out_valid);
        end
    endtask

    task automatic test_single();
        int strobes;
        do_reset();
        InB  = 4'd9;
        req  = 4'b0010;
        last = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0010 || S !== 2'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got gnt=%b S=%0d ov=%b want 0010 1 0", gnt, S, out_valid);
        end
        strobes = 0;
        for (int b = 1; b <= 3; b++) begin
            if (b == 3) last = 4'b0010;
            step();
            if (out_valid === 1'b1 && Out === 4'd9) strobes++;
        end
        req  = '0;
        last = '0;
        step();
        checks++;
        if (strobes != 3) begin
            failures++;
            $display("FAIL single_strobes got %0d want 3", strobes);
        end
        checks++;
        if (gnt !== 4'b0000 || S !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got gnt=%b S=%0d ov=%b want 0000 0 0", gnt, S, out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_s [6]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_out [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        do_reset();
        InA  = 4'd1;
        InB  = 4'd2;
        InC  = 4'd3;
        InD  = 4'd4;
        req  = 4'b1111;
        last = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (S !== exp_s[k] || gnt !== (4'b0001 << exp_s[k]) ||
                out_valid !== (k != 0) || Out !== exp_out[k]) begin
                failures++;
                $display("FAIL rr_cycle%0d got S=%0d gnt=%b ov=%b Out=%0d want S=%0d ov=%b Out=%0d",
                         k, S, gnt, out_valid, Out, exp_s[k], (k != 0), exp_out[k]);
            end
        end
        req  = '0;
        last = '0;
        step();
        step();
    endtask

    task automatic test_forced_release();
        logic [3:0] exp_gnt [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                     4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        logic [3:0] exp_out [10] = '{4'h0, 4'h5, 4'h5, 4'h5, 4'h5,
                                     4'hC, 4'hC, 4'hC, 4'hC, 4'h5};
        do_reset();
        InA  = 4'h5;
        InC  = 4'hC;
        req  = 4'b0101;
        last = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (gnt !== exp_gnt[k] || out_valid !== (k != 0) || Out !== exp_out[k]) begin
                failures++;
                $display("FAIL forced_cycle%0d got gnt=%b ov=%b Out=%h want gnt=%b ov=%b Out=%h",
                         k, gnt, out_valid, Out, exp_gnt[k], (k != 0), exp_out[k]);
            end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_owner_drop();
        do_reset();
        InA  = 4'h6;
        InD  = 4'hD;
        req  = 4'b1001;
        last = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL drop_grant got gnt=%b want 0001", gnt);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || Out !== 4'h6) begin
            failures++;
            $display("FAIL drop_beat2 got ov=%b Out=%h want 1 6", out_valid, Out);
        end
        req = 4'b1000;
        step();
        checks++;
        if (out_valid !== 1'b0 || gnt !== 4'b1000 || S !== 2'd3 || Out !== 4'h6) begin
            failures++;
            $display("FAIL drop_switch got ov=%b gnt=%b S=%0d Out=%h want 0 1000 3 6", out_valid, gnt, S, Out);
        end
        checks++;
        if (dut.ptr !== 2'd1) begin
            failures++;
            $display("FAIL drop_ptr got %0d want 1", dut.ptr);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        InA  = 4'h3;
        InC  = 4'h7;
        req  = 4'b0100;
        last = 4'b0000;
        step();
        step();
        checks++;
        if (gnt !== 4'b0100 || S !== 2'd2 || out_valid !== 1'b1 || Out !== 4'h7) begin
            failures++;
            $display("FAIL areset_pre got gnt=%b S=%0d ov=%b Out=%h want 0100 2 1 7", gnt, S, out_valid, Out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, S, Out, out_valid} !== 11'd0) begin
            failures++;
            $display("FAIL areset_now got gnt=%b S=%0d Out=%h ov=%b want all 0", gnt, S, Out, out_valid);
        end
        req = 4'b0101;
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001 || S !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_restart got gnt=%b S=%0d ov=%b want 0001 0 0", gnt, S, out_valid);
        end
        req = '0;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        last     = '0;
        InA      = '0;
        InB      = '0;
        InC      = '0;
        InD      = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_forced_release();
        test_owner_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
